// File: rtl/avmm_rw_arbiter.sv
// avmm_rw_arbiter
// Two-requester round-robin arbiter in front of one 64-bit Avalon-MM
// read/write master with no waitrequest and a fixed read latency.
// One transfer is granted per cycle. The winning command is registered onto
// the shared m_* port. Read data returns to the issuing requester through a
// {valid, id} tag pipeline whose length matches the downstream read latency.
//
// Parameters
//   READ_LATENCY  cycles from m_read to m_readdata valid (1..8)
// Ports
//   clock, reset                       clock, synchronous active-high reset
//   rN_address/byteenable/writedata    requester N command fields (N = 0, 1)
//   rN_read, rN_write                  requester N request strobes
//   rN_waitrequest                     request N active but not granted
//   rN_readdata, rN_readdatavalid      read response to requester N
//   rN_lock                            keep ownership (AVMM_RW_ARBITER_LOCK_EN only)
//   m_address/byteenable/writedata     shared port command fields
//   m_read, m_write                    shared port strobes
//   m_readdata                         shared port read data
// Build option
//   AVMM_RW_ARBITER_LOCK_EN            adds rN_lock ports and grant locking
module avmm_rw_arbiter #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] r0_address,
    input  logic [7:0]  r0_byteenable,
    input  logic        r0_read,
    input  logic        r0_write,
    input  logic [63:0] r0_writedata,
    output logic        r0_waitrequest,
    output logic [63:0] r0_readdata,
    output logic        r0_readdatavalid,
    input  logic [63:0] r1_address,
    input  logic [7:0]  r1_byteenable,
    input  logic        r1_read,
    input  logic        r1_write,
    input  logic [63:0] r1_writedata,
    output logic        r1_waitrequest,
    output logic [63:0] r1_readdata,
    output logic        r1_readdatavalid,
`ifdef AVMM_RW_ARBITER_LOCK_EN
    input  logic        r0_lock,
    input  logic        r1_lock,
`endif
    output logic [63:0] m_address,
    output logic [7:0]  m_byteenable,
    output logic        m_read,
    output logic        m_write,
    output logic [63:0] m_writedata,
    input  logic [63:0] m_readdata
);

    logic        act0, act1;
    logic        last;
    logic        lock_hold;
    logic        grant0, grant1;
    logic        accept;
    logic        win_id;
    logic [63:0] win_address;
    logic [7:0]  win_byteenable;
    logic [63:0] win_writedata;
    logic        win_read;
    logic        win_write;

    logic [READ_LATENCY:0] tag_v;
    logic [READ_LATENCY:0] tag_id;

    always_comb begin
        act0 = r0_read | r0_write;
        act1 = r1_read | r1_write;

`ifdef AVMM_RW_ARBITER_LOCK_EN
        // The previous winner keeps the port while it stays active with lock set.
        lock_hold = last ? (r1_lock & act1) : (r0_lock & act0);
`else
        lock_hold = 1'b0;
`endif

        // Under contention the requester that did not win last time goes next.
        grant0 = act0 & (~act1 | last);
        grant1 = act1 & (~act0 | ~last);
        if (lock_hold) begin
            grant0 = ~last;
            grant1 = last;
        end

        accept = grant0 | grant1;
        win_id = grant1;

        if (grant1) begin
            win_address    = r1_address;
            win_byteenable = r1_byteenable;
            win_writedata  = r1_writedata;
            win_write      = r1_write;
            win_read       = r1_read & ~r1_write;
        end else begin
            win_address    = r0_address;
            win_byteenable = r0_byteenable;
            win_writedata  = r0_writedata;
            win_write      = r0_write;
            win_read       = r0_read & ~r0_write;
        end

        r0_waitrequest = act0 & ~grant0;
        r1_waitrequest = act1 & ~grant1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last         <= 1'b1;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            tag_v        <= '0;
            tag_id       <= '0;
        end else begin
            m_read  <= accept & win_read;
            m_write <= accept & win_write;
            if (accept) begin
                last         <= win_id;
                m_address    <= win_address;
                m_byteenable <= win_byteenable;
                m_writedata  <= win_writedata;
            end
            // Stage 0 is loaded every cycle so the tail lines up with m_readdata.
            tag_v  <= {tag_v[READ_LATENCY-1:0], accept & win_read};
            tag_id <= {tag_id[READ_LATENCY-1:0], win_id};
        end
    end

    always_comb begin
        r0_readdata      = m_readdata;
        r1_readdata      = m_readdata;
        r0_readdatavalid = tag_v[READ_LATENCY] & ~tag_id[READ_LATENCY];
        r1_readdatavalid = tag_v[READ_LATENCY] &  tag_id[READ_LATENCY];
    end

endmodule

// File: doc/avmm_rw_arbiter.md
# avmm_rw_arbiter

Two-requester round-robin arbiter sharing one 64-bit Avalon-MM read/write master port (the kernel's `avmm_0_rw` style: no waitrequest, fixed read latency) between the HLS kernel and a host/debug requester. Grants one transfer per cycle, registers the winning command onto the shared port and routes fixed-latency read data back to the issuing requester via a tag pipeline. Sits between the kernel top and the memory-side interconnect.

## Interface
- `READ_LATENCY`, 2, downstream cycles from read command to `m_readdata` valid (1..8)
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `rN_address`  in  64  requester N address (N = 0, 1)
- `rN_byteenable`  in  8  requester N byte enables
- `rN_read`  in  1  requester N read request
- `rN_write`  in  1  requester N write request
- `rN_writedata`  in  64  requester N write data
- `rN_waitrequest`  out  1  request not accepted this cycle
- `rN_readdata`  out  64  read data to requester N
- `rN_readdatavalid`  out  1  `rN_readdata` valid
- `rN_lock`  in  1  hold grant across cycles (only with `AVMM_RW_ARBITER_LOCK_EN`)
- `m_address`  out  64  shared port address
- `m_byteenable`  out  8  shared port byte enables
- `m_read`  out  1  shared port read
- `m_write`  out  1  shared port write
- `m_writedata`  out  64  shared port write data
- `m_readdata`  in  64  shared port read data, valid `READ_LATENCY` cycles after `m_read`

## Operation
- Request N active = `rN_read | rN_write`. Both active with same flags: `rN_write` wins, read ignored for that transfer.
- Grant: combinational from active requests and 1-bit `last` pointer. One active → it wins. Both active → requester != `last` wins. Neither → no grant.
- `rN_waitrequest` = request N active and not granted; 0 when N idle.
- Accept (N active, `rN_waitrequest`=0): `last` <= N; winner's address/byteenable/writedata/read/write registered onto `m_*` next cycle. No accept: `m_read`=`m_write`=0 next cycle, data fields hold.
- Tag pipeline: `READ_LATENCY+1`-stage shift register of {valid, id}; stage 0 loaded on every cycle with {accepted read, winner id}.
- Output stage: `rN_readdatavalid` = tail valid and tail id == N; `rN_readdata` = `m_readdata` unconditionally (both requesters).
- Writes produce no response.

## Timing
- Reset: all `m_*`=0, `rN_readdatavalid`=0, tag pipeline cleared, `last`=1 (r0 favored first). `rN_waitrequest` follows combinational rule (0 unless contended).
- Accept at cycle T → `m_read`/`m_write` high in T+1 → `rN_readdatavalid` high in T+1+`READ_LATENCY`.
- Throughput: one transfer per cycle; continuous contention alternates r0, r1, r0, ...
- Reads from different requesters return in issue order, back-to-back, no bubbles.
- Reset mid-flight: in-flight reads discarded (no `readdatavalid` after reset); `m_*` drop to 0 in the cycle after reset asserted.
- Requester may change inputs while `rN_waitrequest`=1; arbiter samples only at accept.

## Configuration
- `AVMM_RW_ARBITER_LOCK_EN` defined: `rN_lock` ports exist. While the current owner (`last`) has `rN_lock`=1, it wins every cycle it is active, even under contention; the other requester stalls. Lock released when owner's `rN_lock`=0 or owner goes idle for a cycle. Enables atomic read-modify-write sequences.
- Undefined: `rN_lock` ports absent; pure round-robin as above.

## Test plan
- Single r0 read addr 0x1000, `READ_LATENCY`=2: accept T0, `m_read`=1 addr 0x1000 at T1, `r0_readdatavalid`=1 with `m_readdata` at T3, `r1_readdatavalid` stays 0.
- r0 and r1 both write for 4 cycles from reset: grants r0, r1, r0, r1; `m_writedata` sequence matches; each `rN_waitrequest` high on alternate cycles.
- Interleaved reads r0@0x0, r1@0x8, r0@0x10 back-to-back: `readdatavalid` pulses r0, r1, r0 on consecutive cycles, correctly steered.
- `r0_read`=`r0_write`=1 same cycle: `m_write`=1, `m_read`=0, no `r0_readdatavalid`.
- Reset asserted one cycle after read accept: `m_*` 0 after reset, no `readdatavalid` ever for that read.
- With `AVMM_RW_ARBITER_LOCK_EN`: r0 locked with r1 contending 3 cycles → r0 granted 3 times, r1 granted first cycle after `r0_lock`=0.
